// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: sequences every access to the single-port data memory
// behind the MEM stage, shares it between the CPU and an external loader/debug
// port, models the fixed read latency and stalls the CPU until its access ends.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration; the
// default build uses fixed CPU-over-EXT priority.
module dmem_access_arbiter #(
  parameter int DATA_W  = 18,
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_gnt_o,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWNER_EXT, OWNER_CPU} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_cpu;
  logic              done_cpu;
  logic              done_ext;

`ifdef DMEM_ARB_RR_EN
  owner_t last_owner_q, last_owner_d;

  // On a tie the requester that did not win the previous arbitration goes first
  always_comb begin
    grant_cpu = cpu_req_i;
    if (cpu_req_i && ext_req_i) begin
      grant_cpu = (last_owner_q == OWNER_EXT);
    end
  end

  // Remember the winner of every IDLE->ISSUE arbitration
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == IDLE && (cpu_req_i || ext_req_i)) begin
      last_owner_d = grant_cpu ? OWNER_CPU : OWNER_EXT;
    end
  end

  // Round-robin history register; EXT after reset so the CPU wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= OWNER_EXT;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign grant_cpu = cpu_req_i;
`endif

  // Next-state logic: arbitrate in IDLE, issue once, count out the read latency
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i || ext_req_i) begin
          state_d = ISSUE;
          if (grant_cpu) begin
            owner_d = OWNER_CPU;
            we_d    = cpu_we_i;
            addr_d  = cpu_addr_i;
            wdata_d = cpu_wdata_i;
          end else begin
            owner_d = OWNER_EXT;
            we_d    = ext_we_i;
            addr_d  = ext_addr_i;
            wdata_d = ext_wdata_i;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdata_d = mem_rdata_i;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers; reset drops any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_EXT;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory strobes come only from registers; completion is the DONE cycle
  assign mem_en_o    = (state_q == ISSUE);
  assign mem_we_o    = (state_q == ISSUE) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign done_cpu    = (state_q == DONE) && (owner_q == OWNER_CPU);
  assign done_ext    = (state_q == DONE) && (owner_q == OWNER_EXT);
  assign cpu_rdata_o = done_cpu ? rdata_q : '0;
  assign cpu_stall_o = cpu_req_i && !done_cpu;
  assign ext_gnt_o   = done_ext;
  assign ext_rdata_o = done_ext ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Testbench for dmem_access_arbiter: directed accesses on a MEM_LAT=2 instance
// and a MEM_LAT=1 instance, each backed by a behavioural memory. Expected
// memory commands and completions are queued by the stimulus and checked by
// an independent monitor.
module tb_dmem_access_arbiter;

  typedef struct {
    bit          chkData;
    logic [17:0] data;
    int          cyc;
  } respT;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [17:0] wdata;
    int          cyc;
  } cmdT;

  logic clk = 1'b0;
  logic rst;
  logic l1Rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        cpuReq, cpuWe, cpuStall, extReq, extWe, extGnt, memEn, memWe;
  logic [9:0]  cpuAddr, extAddr, memAddr;
  logic [17:0] cpuWdata, cpuRdata, extWdata, extRdata, memWdata, memRdata;

  logic        l1Req, l1We, l1Stall, l1Gnt, l1MemEn, l1MemWe;
  logic [9:0]  l1Addr, l1MemAddr;
  logic [17:0] l1Wdata, l1Rdata, l1ExtRdata, l1MemWdata, l1MemRdata;

  logic [17:0] mem [0:1023];
  logic [17:0] l1Mem [0:1023];
  logic [17:0] pipe0, pipe1, l1Pipe;

  respT cpuQ[$], extQ[$], l1Q[$];
  cmdT  memQ[$];
  respT r;
  cmdT  c;

  dmem_access_arbiter #(.DATA_W(18), .ADDR_W(10), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpuReq), .cpu_we_i(cpuWe), .cpu_addr_i(cpuAddr), .cpu_wdata_i(cpuWdata),
    .cpu_rdata_o(cpuRdata), .cpu_stall_o(cpuStall),
    .ext_req_i(extReq), .ext_we_i(extWe), .ext_addr_i(extAddr), .ext_wdata_i(extWdata),
    .ext_gnt_o(extGnt), .ext_rdata_o(extRdata),
    .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata)
  );

  dmem_access_arbiter #(.DATA_W(18), .ADDR_W(10), .MEM_LAT(1)) dutLat1 (
    .clk(clk), .rst(l1Rst),
    .cpu_req_i(l1Req), .cpu_we_i(l1We), .cpu_addr_i(l1Addr), .cpu_wdata_i(l1Wdata),
    .cpu_rdata_o(l1Rdata), .cpu_stall_o(l1Stall),
    .ext_req_i(1'b0), .ext_we_i(1'b0), .ext_addr_i(10'h000), .ext_wdata_i(18'h00000),
    .ext_gnt_o(l1Gnt), .ext_rdata_o(l1ExtRdata),
    .mem_en_o(l1MemEn), .mem_we_o(l1MemWe), .mem_addr_o(l1MemAddr), .mem_wdata_o(l1MemWdata),
    .mem_rdata_i(l1MemRdata)
  );

  always #5 clk = ~clk;

  // Cycle index; stimulus and monitor both read it after the rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memories: preset to {8'hA5, addr}; reads return junk unless issued
  assign memRdata   = pipe1;
  assign l1MemRdata = l1Pipe;
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i]   <= {8'hA5, 10'(i)};
        l1Mem[i] <= {8'hA5, 10'(i)};
      end
    end else begin
      if (memEn && memWe) mem[memAddr] <= memWdata;
      if (l1MemEn && l1MemWe) l1Mem[l1MemAddr] <= l1MemWdata;
    end
    pipe0  <= (memEn && !memWe) ? mem[memAddr] : 18'h2AAAA;
    pipe1  <= pipe0;
    l1Pipe <= (l1MemEn && !l1MemWe) ? l1Mem[l1MemAddr] : 18'h2AAAA;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportMissing(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=none expected=entry (cycle %0d)", name, cyc);
  endtask

  function automatic void pushCmd(input logic we, input logic [9:0] a, input logic [17:0] d, input int cy);
    memQ.push_back('{we, a, d, cy});
  endfunction

  // Monitor: every completion or memory command pops and checks one expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (cpuReq && !cpuStall) begin
        if (cpuQ.size() == 0) reportMissing("cpu_unexpected_done");
        else begin
          r = cpuQ.pop_front();
          checkOutput("cpu_done_cycle", cyc, r.cyc);
          if (r.chkData) checkOutput("cpu_rdata", cpuRdata, r.data);
        end
      end
      if (extGnt) begin
        if (extQ.size() == 0) reportMissing("ext_unexpected_gnt");
        else begin
          r = extQ.pop_front();
          checkOutput("ext_gnt_cycle", cyc, r.cyc);
          if (r.chkData) checkOutput("ext_rdata", extRdata, r.data);
        end
      end
      if (memEn) begin
        if (memQ.size() == 0) reportMissing("mem_unexpected_cmd");
        else begin
          c = memQ.pop_front();
          checkOutput("mem_cmd_cycle", cyc, c.cyc);
          checkOutput("mem_we", memWe, c.we);
          checkOutput("mem_addr", memAddr, c.addr);
          if (c.we) checkOutput("mem_wdata", memWdata, c.wdata);
        end
      end
      if (!cpuReq && extReq) checkOutput("cpu_stall_during_ext", cpuStall, 0);
    end
    if (!l1Rst && l1Req && !l1Stall) begin
      if (l1Q.size() == 0) reportMissing("lat1_unexpected_done");
      else begin
        r = l1Q.pop_front();
        checkOutput("lat1_done_cycle", cyc, r.cyc);
        if (r.chkData) checkOutput("lat1_rdata", l1Rdata, r.data);
      end
    end
  end

  // Wait (bounded) for the CPU access to finish, then hold or drop the request
  task automatic finishCpu(input bit hold);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cpuStall && n < 50);
    if (cpuStall) reportMissing("cpu_timeout");
    @(posedge clk); #1;
    if (!hold) cpuReq = 1'b0;
  endtask

  task automatic cpuDrive(input logic we, input logic [9:0] a, input logic [17:0] d, input bit hold);
    cpuReq = 1'b1; cpuWe = we; cpuAddr = a; cpuWdata = d;
    finishCpu(hold);
  endtask

  task automatic extDrive(input logic we, input logic [9:0] a, input logic [17:0] d);
    int n = 0;
    extReq = 1'b1; extWe = we; extAddr = a; extWdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (!extGnt && n < 50);
    if (!extGnt) reportMissing("ext_timeout");
    @(posedge clk); #1;
    extReq = 1'b0;
  endtask

  // Lone CPU access on an idle arbiter: store ends in cycle 2, load in cycle 4
  task automatic applyStimulus(input logic we, input logic [9:0] a, input logic [17:0] d);
    int s = cyc;
    pushCmd(we, a, d, s + 1);
    cpuQ.push_back('{!we, d, we ? s + 2 : s + 4});
    cpuDrive(we, a, d, 1'b0);
  endtask

  task automatic extAccess(input logic we, input logic [9:0] a, input logic [17:0] d);
    int s = cyc;
    pushCmd(we, a, d, s + 1);
    extQ.push_back('{!we, d, we ? s + 2 : s + 4});
    extDrive(we, a, d);
  endtask

  task automatic l1Access(input logic we, input logic [9:0] a, input logic [17:0] d);
    int n = 0;
    l1Q.push_back('{!we, d, we ? cyc + 2 : cyc + 3});
    l1Req = 1'b1; l1We = we; l1Addr = a; l1Wdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (l1Stall && n < 50);
    if (l1Stall) reportMissing("lat1_timeout");
    @(posedge clk); #1;
    l1Req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    rst = 1'b1; l1Rst = 1'b1;
    cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWdata = '0;
    extReq = 0; extWe = 0; extAddr = '0; extWdata = '0;
    l1Req = 0; l1We = 0; l1Addr = '0; l1Wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_en", memEn, 0);
    checkOutput("rst_mem_we", memWe, 0);
    checkOutput("rst_mem_addr", memAddr, 0);
    checkOutput("rst_mem_wdata", memWdata, 0);
    checkOutput("rst_cpu_rdata", cpuRdata, 0);
    checkOutput("rst_ext_gnt", extGnt, 0);
    checkOutput("rst_ext_rdata", extRdata, 0);
    checkOutput("rst_cpu_stall_low", cpuStall, 0);
    cpuReq = 1'b1;
    #1;
    checkOutput("rst_cpu_stall_follows_req", cpuStall, 1);
    cpuReq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] CPU store/load, EXT write/read");
    applyStimulus(1'b1, 10'h005, 18'h3FFFF);
    applyStimulus(1'b0, 10'h005, 18'h3FFFF);
    extAccess(1'b1, 10'h3FE, 18'h15555);
    applyStimulus(1'b0, 10'h3FE, 18'h15555);
    extAccess(1'b0, 10'h3FF, 18'h297FF);

    $display("[TB] CPU and EXT requesting together");
    s = cyc;
`ifdef DMEM_ARB_RR_EN
    pushCmd(1'b1, 10'h010, 18'h00111, s + 1);
    pushCmd(1'b0, 10'h3FF, 18'h00000, s + 4);
    pushCmd(1'b1, 10'h011, 18'h00222, s + 9);
    pushCmd(1'b1, 10'h012, 18'h00333, s + 12);
    cpuQ.push_back('{1'b0, 18'h0, s + 2});
    cpuQ.push_back('{1'b0, 18'h0, s + 10});
    cpuQ.push_back('{1'b0, 18'h0, s + 13});
    extQ.push_back('{1'b1, 18'h297FF, s + 7});
`else
    pushCmd(1'b1, 10'h010, 18'h00111, s + 1);
    pushCmd(1'b1, 10'h011, 18'h00222, s + 4);
    pushCmd(1'b1, 10'h012, 18'h00333, s + 7);
    pushCmd(1'b0, 10'h3FF, 18'h00000, s + 10);
    cpuQ.push_back('{1'b0, 18'h0, s + 2});
    cpuQ.push_back('{1'b0, 18'h0, s + 5});
    cpuQ.push_back('{1'b0, 18'h0, s + 8});
    extQ.push_back('{1'b1, 18'h297FF, s + 13});
`endif
    fork
      begin
        cpuDrive(1'b1, 10'h010, 18'h00111, 1'b1);
        cpuDrive(1'b1, 10'h011, 18'h00222, 1'b1);
        cpuDrive(1'b1, 10'h012, 18'h00333, 1'b0);
      end
      extDrive(1'b0, 10'h3FF, 18'h00000);
    join
    @(posedge clk); #1;
    applyStimulus(1'b0, 10'h012, 18'h00333);

    $display("[TB] reset during a CPU load");
    s = cyc;
    pushCmd(1'b0, 10'h005, 18'h00000, s + 1);
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 10'h005;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("midrst_mem_en", memEn, 0);
    checkOutput("midrst_cpu_rdata", cpuRdata, 0);
    checkOutput("midrst_cpu_stall", cpuStall, 1);
    checkOutput("midrst_ext_gnt", extGnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    s = cyc;
    pushCmd(1'b0, 10'h005, 18'h00000, s + 1);
    cpuQ.push_back('{1'b1, 18'h3FFFF, s + 4});
    finishCpu(1'b0);

    $display("[TB] MEM_LAT=1 instance");
    checkOutput("lat1_rst_mem_en", l1MemEn, 0);
    checkOutput("lat1_rst_rdata", l1Rdata, 0);
    l1Rst = 1'b0;
    @(posedge clk); #1;
    l1Access(1'b1, 10'h007, 18'h12345);
    l1Access(1'b0, 10'h007, 18'h12345);
    l1Access(1'b0, 10'h100, 18'h29500);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("cpu_queue_drained", cpuQ.size(), 0);
    checkOutput("ext_queue_drained", extQ.size(), 0);
    checkOutput("mem_queue_drained", memQ.size(), 0);
    checkOutput("lat1_queue_drained", l1Q.size(), 0);
    checkOutput("lat1_ext_gnt_idle", l1Gnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
